// File: rtl/spi_slave.sv
// SPI mode-0 target: oversampled pins, TX holding register, RX queue with sticky error flags.
// Build option: define SPI_SLAVE_RXFIFO_EN for a 4-deep RX FIFO (default is a single RX register).
module spi_slave #(
   parameter logic [7:0] FILL_BYTE   = 8'hFF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       spi_cs_n,
   input  logic       spi_di,
   output logic       spi_do,
   output logic       spi_do_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_empty,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   input  logic       rx_rd,
   output logic       overrun,
   output logic       underrun,
   input  logic       err_clr,
   output logic       busy
);

   logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, di_sync_reg;
   logic sclk_dly_reg, cs_dly_reg;
   logic sclk_s, cs_s, di_s;
   logic cs_fall, cs_rise, sclk_rise, sclk_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_reg <= '0;
         cs_sync_reg   <= '1;
         di_sync_reg   <= '0;
         sclk_dly_reg  <= 1'b0;
         cs_dly_reg    <= 1'b1;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
         di_sync_reg   <= {di_sync_reg[SYNC_STAGES-2:0], spi_di};
         sclk_dly_reg  <= sclk_sync_reg[SYNC_STAGES-1];
         cs_dly_reg    <= cs_sync_reg[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
   assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
   assign di_s      = di_sync_reg[SYNC_STAGES-1];
   assign cs_fall   = cs_dly_reg & ~cs_s;
   assign cs_rise   = ~cs_dly_reg & cs_s;
   assign sclk_rise = sclk_s & ~sclk_dly_reg & ~cs_s;
   assign sclk_fall = ~sclk_s & sclk_dly_reg & ~cs_s;

   logic [2:0] bit_cnt_reg;
   logic [7:0] rx_shift_reg;
   logic       push_reg;
   logic [7:0] tx_shift_reg, tx_shift_next;
   logic [7:0] tx_hold_reg, tx_hold_next;
   logic       tx_empty_reg, tx_empty_next;
   logic [7:0] cur_byte_reg, cur_byte_next;
   logic       cur_fill_reg, cur_fill_next;
   logic       pending_reg, pending_next;
   logic       load, unr_evt, ovr_evt, pop, accept;
   logic       overrun_reg, underrun_reg;

   // An aborted byte is restored into tx_shift and re-sent whole by the next frame.
   always_comb begin
      tx_shift_next = tx_shift_reg;
      tx_hold_next  = tx_hold_reg;
      tx_empty_next = tx_empty_reg;
      cur_byte_next = cur_byte_reg;
      cur_fill_next = cur_fill_reg;
      pending_next  = pending_reg;
      load          = (cs_fall & ~pending_reg) | (sclk_fall & (bit_cnt_reg == 3'd0));
      if (cs_fall)
         pending_next = 1'b0;
      if (load) begin
         if (!tx_empty_reg) begin
            tx_shift_next = tx_hold_reg;
            cur_byte_next = tx_hold_reg;
            cur_fill_next = 1'b0;
            tx_empty_next = 1'b1;
         end else begin
            tx_shift_next = FILL_BYTE;
            cur_byte_next = FILL_BYTE;
            cur_fill_next = 1'b1;
         end
      end else if (sclk_fall) begin
         tx_shift_next = {tx_shift_reg[6:0], 1'b1};
      end else if (cs_rise && bit_cnt_reg != 3'd0) begin
         tx_shift_next = cur_byte_reg;
         pending_next  = ~cur_fill_reg;
      end
      if (tx_wr) begin
         tx_hold_next  = tx_data;
         tx_empty_next = 1'b0;
      end
   end

   // Underrun counts only once the master clocks a fill bit, so the trailing load is harmless.
   assign unr_evt = sclk_rise & cur_fill_reg & (bit_cnt_reg == 3'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_reg  <= 3'd0;
         rx_shift_reg <= 8'h00;
         push_reg     <= 1'b0;
         tx_shift_reg <= FILL_BYTE;
         tx_hold_reg  <= 8'h00;
         tx_empty_reg <= 1'b1;
         cur_byte_reg <= FILL_BYTE;
         cur_fill_reg <= 1'b1;
         pending_reg  <= 1'b0;
         overrun_reg  <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         if (cs_fall || cs_rise)
            bit_cnt_reg <= 3'd0;
         else if (sclk_rise)
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
         if (sclk_rise)
            rx_shift_reg <= {rx_shift_reg[6:0], di_s};
         push_reg     <= sclk_rise & (bit_cnt_reg == 3'd7);
         tx_shift_reg <= tx_shift_next;
         tx_hold_reg  <= tx_hold_next;
         tx_empty_reg <= tx_empty_next;
         cur_byte_reg <= cur_byte_next;
         cur_fill_reg <= cur_fill_next;
         pending_reg  <= pending_next;
         overrun_reg  <= ovr_evt | (overrun_reg & ~err_clr);
         underrun_reg <= unr_evt | (underrun_reg & ~err_clr);
      end
   end

`ifdef SPI_SLAVE_RXFIFO_EN
   logic [7:0] mem_reg [4];
   logic [1:0] wptr_reg, rptr_reg;
   logic       full_reg, fifo_empty;

   assign fifo_empty = (wptr_reg == rptr_reg) & ~full_reg;
   assign pop        = rx_rd & ~fifo_empty;
   assign accept     = push_reg & (~full_reg | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            mem_reg[i] <= 8'h00;
         wptr_reg <= 2'd0;
         rptr_reg <= 2'd0;
         full_reg <= 1'b0;
      end else begin
         if (accept) begin
            mem_reg[wptr_reg] <= rx_shift_reg;
            wptr_reg          <= wptr_reg + 2'd1;
         end
         if (pop)
            rptr_reg <= rptr_reg + 2'd1;
         if (accept && !pop && (wptr_reg + 2'd1 == rptr_reg))
            full_reg <= 1'b1;
         else if (pop && !accept)
            full_reg <= 1'b0;
      end
   end

   assign rx_data  = mem_reg[rptr_reg];
   assign rx_avail = ~fifo_empty;
`else
   logic [7:0] rx_hold_reg;
   logic       rx_valid_reg;

   assign pop    = rx_rd & rx_valid_reg;
   assign accept = push_reg & (~rx_valid_reg | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_hold_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
      end else if (accept) begin
         rx_hold_reg  <= rx_shift_reg;
         rx_valid_reg <= 1'b1;
      end else if (pop) begin
         rx_valid_reg <= 1'b0;
      end
   end

   assign rx_data  = rx_hold_reg;
   assign rx_avail = rx_valid_reg;
`endif

   assign ovr_evt   = push_reg & ~accept;
   assign overrun   = overrun_reg;
   assign underrun  = underrun_reg;
   assign tx_empty  = tx_empty_reg;
   assign busy      = ~cs_s;
   assign spi_do_oe = ~cs_s;
   assign spi_do    = cs_s ? 1'b1 : tx_shift_reg[7];

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed SPI master frames against a transaction-level model.
// Honours SPI_SLAVE_RXFIFO_EN to pick the expected RX queue depth.
module tb_spi_slave;

   localparam logic [7:0] FILL = 8'hFF;
`ifdef SPI_SLAVE_RXFIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic spi_clk = 1'b0, spi_cs_n = 1'b1, spi_di = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic tx_wr = 1'b0, rx_rd = 1'b0, err_clr = 1'b0;
   logic spi_do, spi_do_oe, tx_empty, rx_avail, overrun, underrun, busy;
   logic [7:0] rx_data;

   int checks = 0, failures = 0;

   // Model: RX queue contents, TX holding register, byte now in the shifter, sticky flags.
   logic [7:0] m_q[$];
   logic [7:0] m_hold = 8'h00, m_cur = FILL;
   bit m_hold_v = 0, m_cur_fill = 1, m_pend = 0, m_ovr = 0, m_unr = 0;
   bit chk_en = 0;

   spi_slave #(.FILL_BYTE(FILL), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_di(spi_di),
      .spi_do(spi_do), .spi_do_oe(spi_do_oe), .tx_data(tx_data), .tx_wr(tx_wr),
      .tx_empty(tx_empty), .rx_data(rx_data), .rx_avail(rx_avail), .rx_rd(rx_rd),
      .overrun(overrun), .underrun(underrun), .err_clr(err_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end else
         $display("ok   %s = %h", name, act);
   endtask

   // Idle-state comparison against the model on every settled cycle.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         bit ok;
         ok = (rx_avail === (m_q.size() > 0)) && (overrun === m_ovr) && (underrun === m_unr)
              && (tx_empty === !m_hold_v) && (busy === 1'b0) && (spi_do_oe === 1'b0)
              && (spi_do === 1'b1);
         if (m_q.size() > 0 && rx_data !== m_q[0])
            ok = 0;
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL model_cmp t=%0t avail=%b/%b data=%h/%h ovr=%b/%b unr=%b/%b txe=%b/%b busy=%b oe=%b do=%b",
                     $time, rx_avail, m_q.size() > 0, rx_data, (m_q.size() > 0) ? m_q[0] : 8'h00,
                     overrun, m_ovr, underrun, m_unr, tx_empty, !m_hold_v, busy, spi_do_oe, spi_do);
         end
      end
   end

   task automatic half();
      repeat (8) @(negedge clk);
   endtask

   task automatic settle();
      repeat (10) @(negedge clk);
      chk_en = 1;
   endtask

   task automatic model_load();
      if (m_hold_v) begin
         m_cur = m_hold; m_hold_v = 0; m_cur_fill = 0;
      end else begin
         m_cur = FILL; m_cur_fill = 1;
      end
   endtask

   task automatic cs_low();
      chk_en = 0;
      @(negedge clk);
      spi_cs_n = 1'b0;
      if (m_pend) m_pend = 0;
      else model_load();
      half();
   endtask

   task automatic cs_high(input int partial);
      chk_en = 0;
      half();
      spi_cs_n = 1'b1;
      if (partial != 0 && !m_cur_fill) m_pend = 1;
   endtask

   task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      logic [7:0] exp_b;
      bit watch, seen;
      int seen_at;
      exp_b = m_cur; miso = 8'h00; seen = 0; seen_at = -1;
      watch = (nbits == 8) && (m_q.size() == 0);
      for (int i = 0; i < nbits; i++) begin
         spi_di = mosi[7-i];
         half();
         miso[7-i] = spi_do;
         if (i == 0 && m_cur_fill) m_unr = 1;
         spi_clk = 1'b1;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (watch && i == 7 && !seen && rx_avail) begin seen = 1; seen_at = c; end
         end
         spi_clk = 1'b0;
      end
      if (nbits == 8) begin
         chk("miso_vs_model", miso, exp_b);
         if (watch) chk("rx_avail_latency_ok", (seen && seen_at >= 2 && seen_at <= 5), 1);
         if (m_q.size() < DEPTH) m_q.push_back(mosi);
         else m_ovr = 1;
         model_load();
      end
   endtask

   task automatic wr(input logic [7:0] d);
      chk_en = 0;
      @(negedge clk); tx_data = d; tx_wr = 1'b1;
      @(negedge clk); tx_wr = 1'b0;
      m_hold = d; m_hold_v = 1;
   endtask

   task automatic rd_strobe();
      chk_en = 0;
      @(negedge clk); rx_rd = 1'b1;
      @(negedge clk); rx_rd = 1'b0;
      if (m_q.size() > 0) void'(m_q.pop_front());
   endtask

   task automatic pop(input logic [7:0] exp);
      chk_en = 0;
      @(negedge clk);
      chk("pop_avail", rx_avail, 1);
      chk("pop_data", rx_data, exp);
      rd_strobe();
   endtask

   task automatic clr();
      chk_en = 0;
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      m_ovr = 0; m_unr = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_do"}, spi_do, 1);
      chk({tag, "_oe"}, spi_do_oe, 0);
      chk({tag, "_txe"}, tx_empty, 1);
      chk({tag, "_avail"}, rx_avail, 0);
      chk({tag, "_rxd"}, rx_data, 8'h00);
      chk({tag, "_ovr"}, overrun, 0);
      chk({tag, "_unr"}, underrun, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst = 1'b0;
      settle();

      // Single byte exchange, then an ignored read on an empty queue.
      wr(8'hA5); settle();
      cs_low(); xfer(8'h3C, 8, b); chk("t1_miso", b, 8'hA5); cs_high(0); settle();
      chk("t1_rxd", rx_data, 8'h3C); chk("t1_txe", tx_empty, 1);
      chk("t1_ovr", overrun, 0); chk("t1_unr", underrun, 0);
      pop(8'h3C); rd_strobe(); settle();
      chk("t1_empty_rd", rx_avail, 0);

      // Two bytes, second TX byte written after the first load.
      wr(8'hA5); settle();
      cs_low(); chk("t2_txe_after_load", tx_empty, 1);
      wr(8'h5A);
      xfer(8'h01, 8, b); chk("t2_miso0", b, 8'hA5);
      pop(8'h01);
      xfer(8'h02, 8, b); chk("t2_miso1", b, 8'h5A);
      cs_high(0); settle();
      pop(8'h02); settle();
      chk("t2_avail", rx_avail, 0);

      // No TX queued: fill byte and underrun, then clear.
      cs_low(); xfer(8'h00, 8, b); chk("t3_miso", b, FILL); cs_high(0); settle();
      chk("t3_unr", underrun, 1);
      clr(); settle();
      chk("t3_unr_clr", underrun, 0);
      pop(8'h00); settle();

      // Five bytes without reading.
      cs_low();
      for (int k = 0; k < 5; k++) xfer(8'h10 + k[7:0], 8, b);
      cs_high(0); settle();
      chk("t4_ovr", overrun, 1);
`ifdef SPI_SLAVE_RXFIFO_EN
      pop(8'h10); pop(8'h11); pop(8'h12); pop(8'h13);
`else
      pop(8'h10);
`endif
      settle();
      chk("t4_avail", rx_avail, 0);
      clr(); settle();

      // Aborted frame keeps its TX byte for the next frame.
      wr(8'hC3); settle();
      cs_low(); xfer(8'hF0, 4, b); chk("t5_partial_miso", b, 8'hC0); cs_high(4); settle();
      chk("t5_no_rx", rx_avail, 0);
      cs_low(); xfer(8'h81, 8, b); chk("t5_miso", b, 8'hC3); cs_high(0); settle();
      chk("t5_unr", underrun, 0);
      pop(8'h81); settle();

      // Overwrite of an unsent holding register.
      wr(8'h11); wr(8'h22); settle();
      cs_low(); xfer(8'h99, 8, b); chk("t7_miso", b, 8'h22); cs_high(0); settle();
      pop(8'h99); settle();
      clr(); settle();

      // Asynchronous reset in the middle of a byte.
      cs_low(); xfer(8'h55, 8, b); xfer(8'hAA, 3, b);
      chk("t6_avail_before", rx_avail, 1);
      @(negedge clk); #2 rst = 1'b1; #1;
      chk_reset("t6_async");
      spi_cs_n = 1'b1; spi_clk = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_q.delete(); m_hold_v = 0; m_pend = 0; m_ovr = 0; m_unr = 0; m_cur = FILL; m_cur_fill = 1;
      settle();
      cs_low(); xfer(8'h77, 8, b); chk("t6_miso", b, FILL); cs_high(0); settle();
      chk("t6_rxd", rx_data, 8'h77);
      pop(8'h77); settle();

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
